// File: rtl/instr_fetch_sequencer.sv
// rtl/instr_fetch_sequencer.sv - PC-driven instruction fetch FSM with two-word support and wait-state timeout
module instr_fetch_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int LONG_BIT   = 15,
  parameter int WAIT_WIDTH = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clock,
  input  logic                  notReset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] pcAddr,
  output logic                  pcNotOE,
  output logic                  pcInc,
  output logic [DATA_WIDTH-1:0] memAddr,
  output logic                  memRead,
  input  logic                  memReady,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic [DATA_WIDTH-1:0] ir,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  isLong,
  output logic                  irValid,
  input  logic                  irConsume,
  output logic                  fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_REQ,
    S_INC,
    S_VALID,
    S_FAULT
  } state_t;

  // Counter value seen during the last permitted REQ cycle.
  localparam logic [WAIT_WIDTH-1:0] LAST_WAIT =
    WAIT_WIDTH'((MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0);
  localparam logic TIMEOUT_ON = (MAX_WAIT != 0);

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   ir_q;
  logic [DATA_WIDTH-1:0]   imm_q;
  logic                    is_long_q;
  logic [WAIT_WIDTH-1:0]   wait_q;
  logic                    second_q;

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      ir_q       <= '0;
      imm_q      <= '0;
      is_long_q  <= 1'b0;
      wait_q     <= '0;
      second_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q  <= S_ADDR;
            second_q <= 1'b0;
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          // Flush overrides every in-flight action, including a ready data beat.
          if (flush) begin
            state_q  <= enable ? S_ADDR : S_IDLE;
            second_q <= 1'b0;
          end else begin
            case (state_q)
              S_ADDR: begin
                mem_addr_q <= pcAddr;
                wait_q     <= '0;
                state_q    <= S_REQ;
              end
              S_REQ: begin
                if (memReady) begin
                  if (!second_q) begin
                    ir_q      <= memData;
                    is_long_q <= memData[LONG_BIT];
                  end else begin
                    imm_q <= memData;
                  end
                  state_q <= S_INC;
                end else begin
                  if (wait_q != '1) begin
                    wait_q <= wait_q + 1'b1;
                  end
                  if (TIMEOUT_ON && (wait_q == LAST_WAIT)) begin
                    state_q <= S_FAULT;
                  end
                end
              end
              S_INC: begin
                if (!second_q && is_long_q) begin
                  second_q <= 1'b1;
                  state_q  <= S_ADDR;
                end else begin
                  state_q <= S_VALID;
                end
              end
              S_VALID: begin
                if (irConsume) begin
                  state_q <= enable ? S_ADDR : S_IDLE;
                end
              end
              default: begin
                state_q <= S_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign pcNotOE = (state_q != S_ADDR);
  assign pcInc   = (state_q == S_INC) && !flush;
  assign memRead = (state_q == S_REQ);
  assign irValid = (state_q == S_VALID);
  assign fault   = (state_q == S_FAULT);
  assign memAddr = mem_addr_q;
  assign ir      = ir_q;
  assign imm     = imm_q;
  assign isLong  = is_long_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb/tb_instr_fetch_sequencer.sv - directed vector bench for instr_fetch_sequencer
module tb_instr_fetch_sequencer;

  logic        clock = 1'b0;
  logic        notReset;
  logic        enable, flush, memReady, irConsume;
  logic [15:0] pcAddr, memData;
  logic        pcNotOE, pcInc, memRead, isLong, irValid, fault;
  logic [15:0] memAddr, ir, imm;

  int checks = 0;
  int errors = 0;

  instr_fetch_sequencer #(
    .DATA_WIDTH(16), .LONG_BIT(15), .WAIT_WIDTH(4), .MAX_WAIT(4)
  ) dut (
    .clock(clock), .notReset(notReset), .enable(enable), .flush(flush),
    .pcAddr(pcAddr), .pcNotOE(pcNotOE), .pcInc(pcInc), .memAddr(memAddr),
    .memRead(memRead), .memReady(memReady), .memData(memData), .ir(ir),
    .imm(imm), .isLong(isLong), .irValid(irValid), .irConsume(irConsume),
    .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        noe, inc, mrd, val, lng, flt;
    logic [15:0] maddr, ir, imm;
  } out_t;

  typedef struct packed {
    logic        en, fl, rdy, cons;
    logic [15:0] pc, data;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic fl, input logic [15:0] pc,
                     input logic rdy, input logic [15:0] data, input logic cons,
                     input logic noe, input logic inc, input logic mrd,
                     input logic val, input logic lng, input logic flt,
                     input logic [15:0] maddr, input logic [15:0] eir,
                     input logic [15:0] eimm);
    vec_t v;
    v.en = en; v.fl = fl; v.pc = pc; v.rdy = rdy; v.data = data; v.cons = cons;
    v.exp.noe = noe; v.exp.inc = inc; v.exp.mrd = mrd; v.exp.val = val;
    v.exp.lng = lng; v.exp.flt = flt; v.exp.maddr = maddr;
    v.exp.ir = eir; v.exp.imm = eimm;
    vecs.push_back(v);
  endtask

  function automatic out_t sample();
    out_t o;
    o.noe = pcNotOE; o.inc = pcInc; o.mrd = memRead; o.val = irValid;
    o.lng = isLong; o.flt = fault; o.maddr = memAddr; o.ir = ir; o.imm = imm;
    return o;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic fl, input logic [15:0] pc,
                       input logic rdy, input logic [15:0] data, input logic cons);
    enable = en; flush = fl; pcAddr = pc; memReady = rdy; memData = data;
    irConsume = cons;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    notReset = 1'b0;
    enable = 0; flush = 0; pcAddr = 0; memReady = 0; memData = 0; irConsume = 0;

    //   en fl pc       rdy data     cons noe inc mrd val lng flt maddr    ir       imm
    add(1, 0, 16'h0000, 0, 16'h0000, 0,  1,  0,  0,  0,  0,  0, 16'h0000, 16'h0000, 16'h0000);
    add(1, 0, 16'h0010, 0, 16'h0000, 0,  0,  0,  0,  0,  0,  0, 16'h0000, 16'h0000, 16'h0000);
    add(1, 0, 16'h0010, 1, 16'h1234, 0,  1,  0,  1,  0,  0,  0, 16'h0010, 16'h0000, 16'h0000);
    add(1, 0, 16'h0010, 0, 16'h0000, 0,  1,  1,  0,  0,  0,  0, 16'h0010, 16'h1234, 16'h0000);
    add(1, 0, 16'h0010, 0, 16'h0000, 1,  1,  0,  0,  1,  0,  0, 16'h0010, 16'h1234, 16'h0000);
    add(1, 0, 16'h0020, 0, 16'h0000, 0,  0,  0,  0,  0,  0,  0, 16'h0010, 16'h1234, 16'h0000);
    add(1, 0, 16'h0020, 1, 16'h8001, 0,  1,  0,  1,  0,  0,  0, 16'h0020, 16'h1234, 16'h0000);
    add(1, 0, 16'h0020, 0, 16'h0000, 0,  1,  1,  0,  0,  1,  0, 16'h0020, 16'h8001, 16'h0000);
    add(1, 0, 16'h0022, 0, 16'h0000, 0,  0,  0,  0,  0,  1,  0, 16'h0020, 16'h8001, 16'h0000);
    add(1, 0, 16'h0022, 1, 16'hBEEF, 0,  1,  0,  1,  0,  1,  0, 16'h0022, 16'h8001, 16'h0000);
    add(0, 0, 16'h0022, 0, 16'h0000, 0,  1,  1,  0,  0,  1,  0, 16'h0022, 16'h8001, 16'hBEEF);
    add(0, 0, 16'h0022, 0, 16'h0000, 0,  1,  0,  0,  1,  1,  0, 16'h0022, 16'h8001, 16'hBEEF);
    add(0, 0, 16'h0022, 0, 16'h0000, 0,  1,  0,  0,  1,  1,  0, 16'h0022, 16'h8001, 16'hBEEF);
    add(0, 0, 16'h0022, 0, 16'h0000, 1,  1,  0,  0,  1,  1,  0, 16'h0022, 16'h8001, 16'hBEEF);
    add(0, 0, 16'h0022, 0, 16'h0000, 0,  1,  0,  0,  0,  1,  0, 16'h0022, 16'h8001, 16'hBEEF);

    #2;
    chk("reset_noe", {15'd0, pcNotOE}, 16'd1);
    chk("reset_flags", {12'd0, pcInc, memRead, irValid, fault}, 16'd0);
    @(negedge clock);
    notReset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      out_t got;
      drive(vecs[i].en, vecs[i].fl, vecs[i].pc, vecs[i].rdy, vecs[i].data, vecs[i].cons);
      got = sample();
      checks++;
      if (got !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec[%0d] got %h expected %h", i, got, vecs[i].exp);
      end
      tick();
    end

    // Wait states: three empty REQ cycles, data on the fourth.
    drive(1, 0, 16'h0030, 0, 16'h0000, 0); tick();
    drive(1, 0, 16'h0030, 0, 16'h0000, 0); tick();
    for (int w = 0; w < 4; w++) begin
      drive(1, 0, 16'h0031, (w == 3), 16'h00AA, 0);
      chk($sformatf("wait_mrd%0d", w), {15'd0, memRead}, 16'd1);
      chk($sformatf("wait_addr%0d", w), memAddr, 16'h0030);
      tick();
    end
    drive(0, 0, 16'h0000, 0, 16'h0000, 0);
    chk("wait_inc", {15'd0, pcInc}, 16'd1);
    tick();
    chk("wait_ir", ir, 16'h00AA);
    chk("wait_state", {12'd0, irValid, isLong, fault, memRead}, 16'b1000);
    drive(0, 0, 16'h0000, 0, 16'h0000, 1); tick();

    // Flush during INC suppresses pcInc and restarts at ADDR.
    drive(1, 0, 16'h0040, 0, 16'h0000, 0); tick();
    drive(1, 0, 16'h0040, 0, 16'h0000, 0); tick();
    drive(1, 0, 16'h0040, 1, 16'h1111, 0); tick();
    drive(1, 1, 16'h0040, 0, 16'h0000, 0);
    chk("flush_inc_pcinc", {15'd0, pcInc}, 16'd0);
    tick();
    drive(1, 0, 16'h0040, 0, 16'h0000, 0);
    chk("flush_inc_next", {14'd0, pcNotOE, irValid}, 16'd0);
    tick();
    drive(1, 0, 16'h0040, 1, 16'h2222, 0); tick();
    drive(1, 0, 16'h0040, 0, 16'h0000, 0); tick();
    drive(1, 1, 16'h0040, 0, 16'h0000, 1);
    chk("flush_valid_before", {15'd0, irValid}, 16'd1);
    chk("flush_valid_ir", ir, 16'h2222);
    tick();
    drive(1, 0, 16'h0050, 0, 16'h0000, 0);
    chk("flush_valid_after", {14'd0, pcNotOE, irValid}, 16'd0);
    tick();
    // Flush while memReady=1 in REQ discards the data beat.
    drive(0, 1, 16'h0050, 1, 16'h3333, 0); tick();
    drive(0, 0, 16'h0000, 0, 16'h0000, 0);
    chk("flush_req_ir", ir, 16'h2222);
    chk("flush_req_idle", {13'd0, pcNotOE, memRead, pcInc}, 16'b100);
    tick();

    // Asynchronous reset in the middle of REQ.
    drive(1, 0, 16'h0060, 0, 16'h0000, 0); tick();
    drive(1, 0, 16'h0060, 0, 16'h0000, 0); tick();
    drive(1, 0, 16'h0060, 0, 16'h0000, 0);
    chk("rst_pre_mrd", {15'd0, memRead}, 16'd1);
    notReset = 1'b0;
    #1;
    chk("rst_async", {12'd0, pcNotOE, memRead, irValid, fault}, 16'b1000);
    chk("rst_ir", ir, 16'h0000);
    @(negedge clock);
    notReset = 1'b1;
    drive(1, 0, 16'h0070, 0, 16'h0000, 0);
    chk("rst_release_idle", {15'd0, pcNotOE}, 16'd1);
    tick();
    chk("rst_release_addr", {15'd0, pcNotOE}, 16'd0);

    // Timeout after four empty REQ cycles.
    tick();
    for (int w = 0; w < 4; w++) begin
      drive(1, 0, 16'h0070, 0, 16'h0000, 0);
      chk($sformatf("to_req%0d", w), {14'd0, memRead, fault}, 16'b10);
      tick();
    end
    drive(1, 1, 16'h0070, 1, 16'h5555, 1);
    chk("to_fault", {13'd0, fault, memRead, pcNotOE}, 16'b101);
    tick();
    tick();
    chk("to_sticky", {12'd0, fault, memRead, irValid, pcNotOE}, 16'b1001);
    notReset = 1'b0;
    #1;
    chk("to_reset_clear", {15'd0, fault}, 16'd0);
    @(negedge clock);
    notReset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
